// File: rtl/can_pkg.sv
// can_pkg: shared CAN bit-level constants and the TX boundary action type.
// Used by can_stuff and can_bit_timer. Optional feature macro: CAN_BIT_MONITOR_EN.
package can_pkg;

    // Bus levels: dominant is the driven low level, recessive is the idle high level.
    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    // Default bit timing and stuffing rule.
    localparam int CAN_CLKS_PER_BIT = 10;
    localparam int CAN_STUFF_LEN    = 5;
    localparam int CAN_SAMPLE_PT    = 7;

    // What the TX register does at the end of the current bit time.
    typedef enum logic [1:0] {
        TX_HOLD  = 2'd0,   // not a boundary cycle, keep the line
        TX_STUFF = 2'd1,   // insert a complementary stuff bit
        TX_DATA  = 2'd2,   // load the offered frame bit
        TX_IDLE  = 2'd3    // nothing offered, go recessive
    } tx_action_t;

    // Width of a counter that must hold 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/can_bit_timer.sv
// can_bit_timer: free-running bit-time counter producing the boundary strobe
// (last cycle of a bit) and, when CAN_BIT_MONITOR_EN is defined, the sample-point strobe.
// Shared between the TX stuffer and the RX destuff path.
module can_bit_timer
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = CAN_CLKS_PER_BIT
`ifdef CAN_BIT_MONITOR_EN
    ,
    parameter int SAMPLE_PT    = CAN_SAMPLE_PT
`endif
) (
    input  logic i_Clock,
    input  logic i_Reset,
    output logic o_Boundary
`ifdef CAN_BIT_MONITOR_EN
    ,
    output logic o_Sample
`endif
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_bit_cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; reset restarts the bit time at 0.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_bit_cnt <= '0;
        end else if (r_bit_cnt == LAST_CNT) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    assign o_Boundary = (r_bit_cnt == LAST_CNT);

`ifdef CAN_BIT_MONITOR_EN
    assign o_Sample = (r_bit_cnt == CNT_W'(SAMPLE_PT));
`endif

endmodule

// File: rtl/can_stuff.sv
// can_stuff: transmit-side CAN bit stuffer and bit-time serializer.
// Accepts one frame bit per bit time over valid/ready and inserts a complementary
// stuff bit after STUFF_LEN equal bits inside the stuff region.
// Optional feature macro: CAN_BIT_MONITOR_EN (adds i_Rx_Serial / o_Bit_Error).
module can_stuff
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = CAN_CLKS_PER_BIT,
    parameter int STUFF_LEN    = CAN_STUFF_LEN
`ifdef CAN_BIT_MONITOR_EN
    ,
    parameter int SAMPLE_PT    = CAN_SAMPLE_PT
`endif
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Stuff_En,
    input  logic i_Tx_Bit,
    input  logic i_Tx_Valid,
    output logic o_Tx_Ready,
    output logic o_Tx_Serial,
    output logic o_Bit_Strobe,
    output logic o_Stuff_Bit,
    output logic o_Underrun
`ifdef CAN_BIT_MONITOR_EN
    ,
    input  logic i_Rx_Serial,
    output logic o_Bit_Error
`endif
);

    localparam int               RUN_W   = cnt_width(STUFF_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic             w_boundary;
    logic             w_stuff_req;
    logic [RUN_W-1:0] w_run_inc;
    tx_action_t       w_action;

    logic [RUN_W-1:0] r_run;          // length of the current equal-bit run on the line
    logic             r_last;         // last bit driven inside the current frame
    logic             r_region;       // stuff-region flag of the last data bit sent
    logic             r_tx_serial;
    logic             r_bit_strobe;
    logic             r_stuff_bit;
    logic             r_underrun;

`ifdef CAN_BIT_MONITOR_EN
    logic w_sample;
    logic r_bit_error;
`endif

    can_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
`ifdef CAN_BIT_MONITOR_EN
        ,
        .SAMPLE_PT    (SAMPLE_PT)
`endif
    ) u_bit_timer (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .o_Boundary (w_boundary)
`ifdef CAN_BIT_MONITOR_EN
        ,
        .o_Sample   (w_sample)
`endif
    );

    // The region flag travels with the last data bit, so a run that completes on the
    // final CRC bit is still stuffed even though i_Stuff_En has already dropped.
    assign w_stuff_req = r_region && (r_run == RUN_MAX);
    assign o_Tx_Ready  = w_boundary && !w_stuff_req;
    // Run length saturates once it reaches STUFF_LEN (only possible outside the region).
    assign w_run_inc   = (r_run == RUN_MAX) ? r_run : (r_run + RUN_ONE);

    // Pick the boundary action: a pending stuff bit beats new data, data beats idle.
    always_comb begin
        w_action = TX_HOLD;
        if (w_boundary) begin
            if (w_stuff_req) begin
                w_action = TX_STUFF;
            end else if (i_Tx_Valid) begin
                w_action = TX_DATA;
            end else begin
                w_action = TX_IDLE;
            end
        end
    end

    // TX line, run tracking and per-bit status; everything updates on the boundary edge.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_run        <= '0;
            r_last       <= CAN_RECESSIVE;
            r_region     <= 1'b0;
            r_tx_serial  <= CAN_RECESSIVE;
            r_bit_strobe <= 1'b0;
            r_stuff_bit  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_bit_strobe <= w_boundary;
            r_underrun   <= 1'b0;
            unique case (w_action)
                TX_STUFF: begin
                    // The stuff bit starts the next run.
                    r_tx_serial <= ~r_last;
                    r_last      <= ~r_last;
                    r_run       <= RUN_ONE;
                    r_stuff_bit <= 1'b1;
                end
                TX_DATA: begin
                    r_tx_serial <= i_Tx_Bit;
                    r_last      <= i_Tx_Bit;
                    r_run       <= (i_Tx_Bit == r_last) ? w_run_inc : RUN_ONE;
                    r_region    <= i_Stuff_En;
                    r_stuff_bit <= 1'b0;
                end
                TX_IDLE: begin
                    r_tx_serial <= CAN_RECESSIVE;
                    r_last      <= CAN_RECESSIVE;
                    r_run       <= '0;
                    r_region    <= 1'b0;
                    r_stuff_bit <= 1'b0;
                    r_underrun  <= i_Stuff_En;
                end
                default: begin
                    r_run <= r_run;
                end
            endcase
        end
    end

    assign o_Tx_Serial  = r_tx_serial;
    assign o_Bit_Strobe = r_bit_strobe;
    assign o_Stuff_Bit  = r_stuff_bit;
    assign o_Underrun   = r_underrun;

`ifdef CAN_BIT_MONITOR_EN
    // Raw read-back mismatch at the sample point; the frame layer decides when it matters.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_bit_error <= 1'b0;
        end else begin
            r_bit_error <= w_sample && (i_Rx_Serial != r_tx_serial);
        end
    end

    assign o_Bit_Error = r_bit_error;
`endif

endmodule
